// File: rtl/pp3_cfrag_pkg.sv
// rtl/pp3_cfrag_pkg.sv - shared types and constants for the PP3 logic-cell fragment array
package pp3_cfrag_pkg;

   typedef enum logic {
      MODE_SINGLE = 1'b0,
      MODE_SPLIT  = 1'b1
   } mode_t;

   localparam int CFG_BITS_PER_CELL = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } cfg_state_t;

endpackage

// File: rtl/c_frag_cell.sv
// rtl/c_frag_cell.sv - one PP3 cell: T/B mux tree, mode select, Q flip-flop and bypass
// Optional PP3_QFRAG_SET_EN adds an asynchronous set input qst.
module c_frag_cell
   import pp3_cfrag_pkg::*;
(
   input  logic  qck,
   input  logic  qrt,
`ifdef PP3_QFRAG_SET_EN
   input  logic  qst,
`endif
   input  mode_t mode,
   input  logic  bypass,
   input  logic  tbs,
   input  logic  tab,
   input  logic  tsl,
   input  logic  ta1,
   input  logic  ta2,
   input  logic  tb1,
   input  logic  tb2,
   input  logic  bab,
   input  logic  bsl,
   input  logic  ba1,
   input  logic  ba2,
   input  logic  bb1,
   input  logic  bb2,
   input  logic  qen,
   output logic  tz,
   output logic  cz,
   output logic  oz
);

   logic t_mux;
   logic b_mux;
   logic qz;

   assign t_mux = tab ? (tsl ? tb2 : tb1) : (tsl ? ta2 : ta1);
   assign b_mux = bab ? (bsl ? bb2 : bb1) : (bsl ? ba2 : ba1);
   assign tz    = t_mux;

   // In split mode the bottom fragment owns cz and tbs has no effect.
   assign cz = (mode == MODE_SPLIT) ? b_mux : (tbs ? b_mux : t_mux);

`ifdef PP3_QFRAG_SET_EN
   always_ff @(posedge qck or posedge qrt or posedge qst) begin
      if (qrt) begin
         qz <= 1'b0;
      end else if (qst) begin
         qz <= 1'b1;
      end else if (qen) begin
         qz <= cz;
      end
   end
`else
   always_ff @(posedge qck or posedge qrt) begin
      if (qrt) begin
         qz <= 1'b0;
      end else if (qen) begin
         qz <= cz;
      end
   end
`endif

   assign oz = bypass ? cz : qz;

endmodule

// File: rtl/c_frag_array.sv
// rtl/c_frag_array.sv - array of PP3 cells with serial, staged-commit per-cell configuration
// Optional PP3_QFRAG_SET_EN adds per-cell asynchronous set port QST.
module c_frag_array
   import pp3_cfrag_pkg::*;
#(
   parameter int N_CELLS = 4,
   parameter int CNT_W   = $clog2(2*N_CELLS+1)
) (
   input  logic               QCK,
   input  logic               QRT,
   input  logic [N_CELLS-1:0] TBS,
   input  logic [N_CELLS-1:0] TAB,
   input  logic [N_CELLS-1:0] TSL,
   input  logic [N_CELLS-1:0] TA1,
   input  logic [N_CELLS-1:0] TA2,
   input  logic [N_CELLS-1:0] TB1,
   input  logic [N_CELLS-1:0] TB2,
   input  logic [N_CELLS-1:0] BAB,
   input  logic [N_CELLS-1:0] BSL,
   input  logic [N_CELLS-1:0] BA1,
   input  logic [N_CELLS-1:0] BA2,
   input  logic [N_CELLS-1:0] BB1,
   input  logic [N_CELLS-1:0] BB2,
   input  logic [N_CELLS-1:0] QEN,
`ifdef PP3_QFRAG_SET_EN
   input  logic [N_CELLS-1:0] QST,
`endif
   input  logic               CFG_EN,
   input  logic               CFG_DI,
   input  logic               CFG_LOAD,
   output logic [N_CELLS-1:0] TZ,
   output logic [N_CELLS-1:0] CZ,
   output logic [N_CELLS-1:0] OZ,
   output logic               CFG_DO,
   output logic               CFG_BUSY,
   output logic               CFG_ERR
);

   localparam int              CFG_W    = CFG_BITS_PER_CELL * N_CELLS;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

   cfg_state_t       state,  state_nx;
   logic [CFG_W-1:0] shadow, shadow_nx;
   logic [CFG_W-1:0] active, active_nx;
   logic [CNT_W-1:0] cnt,    cnt_nx;
   logic             err,    err_nx;

   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         state  <= IDLE;
         shadow <= '0;
         active <= '0;
         cnt    <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         shadow <= shadow_nx;
         active <= active_nx;
         cnt    <= cnt_nx;
         err    <= err_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      shadow_nx = shadow;
      active_nx = active;
      cnt_nx    = cnt;
      err_nx    = err;
      unique case (state)
         IDLE: begin
            if (CFG_EN) begin
               shadow_nx = {shadow[CFG_W-2:0], CFG_DI};
               cnt_nx    = CNT_W'(1);
               state_nx  = SHIFT;
            end
         end
         SHIFT: begin
            // A load in the same cycle as a shift request wins and suppresses the shift.
            if (CFG_LOAD) begin
               state_nx = COMMIT;
            end else if (CFG_EN) begin
               shadow_nx = {shadow[CFG_W-2:0], CFG_DI};
               if (cnt != CNT_SAT) begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         COMMIT: begin
            if (cnt == CNT_FULL) begin
               active_nx = shadow;
               err_nx    = 1'b0;
            end else begin
               err_nx    = 1'b1;
            end
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign CFG_DO   = shadow[CFG_W-1];
   assign CFG_BUSY = (state == SHIFT);
   assign CFG_ERR  = err;

   for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
      c_frag_cell u_cell (
         .qck    (QCK),
         .qrt    (QRT),
`ifdef PP3_QFRAG_SET_EN
         .qst    (QST[i]),
`endif
         .mode   (mode_t'(active[CFG_BITS_PER_CELL*i])),
         .bypass (active[CFG_BITS_PER_CELL*i+1]),
         .tbs    (TBS[i]),
         .tab    (TAB[i]),
         .tsl    (TSL[i]),
         .ta1    (TA1[i]),
         .ta2    (TA2[i]),
         .tb1    (TB1[i]),
         .tb2    (TB2[i]),
         .bab    (BAB[i]),
         .bsl    (BSL[i]),
         .ba1    (BA1[i]),
         .ba2    (BA2[i]),
         .bb1    (BB1[i]),
         .bb2    (BB2[i]),
         .qen    (QEN[i]),
         .tz     (TZ[i]),
         .cz     (CZ[i]),
         .oz     (OZ[i])
      );
   end

endmodule
